// File: rtl/nic_host_ctrl.sv
// nic_host_ctrl: host-side sequencer for one ring NIC processor port.
//
// A local TX FIFO is drained into the NIC output buffer. Received flits are pulled from the
// NIC input buffer into a valid/ready holding register. TX and RX share the single NIC port
// with round-robin priority. Every data access is preceded by a status poll.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   tx_valid/ready/data   producer side, 64-bit flit in [0:63] order
//   rx_valid/ready/data   consumer side, holding register output
//   nic_addr              00 in-buf, 01 in-status, 10 out-buf, 11 out-status
//   nic_d_in/nic_d_out    NIC data (d_out is registered inside the NIC)
//   nic_en/nic_wr_en      NIC access strobes
//   tx_sent_cnt           flits written to the NIC (wraps)
//   rx_recv_cnt           flits read from the NIC (wraps)
//   busy                  sequencer not idle
module nic_host_ctrl #(
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [0:63]      tx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [0:63]      rx_data,
  output logic [1:0]       nic_addr,
  output logic [0:63]      nic_d_in,
  input  logic [0:63]      nic_d_out,
  output logic             nic_en,
  output logic             nic_wr_en,
  output logic [CNT_W-1:0] tx_sent_cnt,
  output logic [CNT_W-1:0] rx_recv_cnt,
  output logic             busy
);

  localparam int unsigned PtrW     = $clog2(TX_DEPTH);
  localparam int unsigned FifoCntW = $clog2(TX_DEPTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StTxStatRd,
    StTxStatChk,
    StTxWr,
    StRxStatRd,
    StRxStatChk,
    StRxDataRd,
    StRxCap
  } state_e;

  state_e state_q, state_d;
  logic   prio_rx_q, prio_rx_d;  // 0: TX wins a tie, 1: RX wins a tie

  // ---------------------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------------------
  logic [0:63]         fifo_mem [TX_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FifoCntW-1:0] fifo_cnt_q;
  logic                push, pop, fifo_empty;

  assign tx_ready   = (fifo_cnt_q != FifoCntW'(TX_DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign push       = tx_valid && tx_ready;
  assign pop        = (state_q == StTxWr);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + FifoCntW'(1);
      end else if (pop && !push) begin
        fifo_cnt_q <= fifo_cnt_q - FifoCntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= tx_data;
  end

  // ---------------------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------------------
  logic status;
  logic tx_cand, rx_cand;
  logic rx_valid_q;

  // Status registers report their flag in the LSB of the [0:63] word.
  assign status  = nic_d_out[63];
  assign tx_cand = !fifo_empty;
  // A draining holding register is free by the time the capture lands.
  assign rx_cand = !rx_valid_q || rx_ready;

  logic             nic_en_q, nic_en_d;
  logic             nic_wr_en_q, nic_wr_en_d;
  logic [1:0]       nic_addr_q, nic_addr_d;
  logic [0:63]      nic_d_in_q, nic_d_in_d;

  // State and registered NIC bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      prio_rx_q   <= 1'b0;
      nic_en_q    <= 1'b0;
      nic_wr_en_q <= 1'b0;
      nic_addr_q  <= 2'b00;
      nic_d_in_q  <= '0;
    end else begin
      state_q     <= state_d;
      prio_rx_q   <= prio_rx_d;
      nic_en_q    <= nic_en_d;
      nic_wr_en_q <= nic_wr_en_d;
      nic_addr_q  <= nic_addr_d;
      nic_d_in_q  <= nic_d_in_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    prio_rx_d = prio_rx_q;
    unique case (state_q)
      StIdle: begin
        if (tx_cand && (!rx_cand || !prio_rx_q)) begin
          state_d = StTxStatRd;
        end else if (rx_cand) begin
          state_d = StRxStatRd;
        end
      end
      StTxStatRd: state_d = StTxStatChk;
      StTxStatChk: begin
        if (status) begin
          state_d   = StIdle;
          prio_rx_d = 1'b1;
        end else begin
          state_d = StTxWr;
        end
      end
      StTxWr: begin
        state_d   = StIdle;
        prio_rx_d = 1'b1;
      end
      StRxStatRd: state_d = StRxStatChk;
      StRxStatChk: begin
        if (status) begin
          state_d = StRxDataRd;
        end else begin
          state_d   = StIdle;
          prio_rx_d = 1'b0;
        end
      end
      StRxDataRd: state_d = StRxCap;
      StRxCap: begin
        state_d   = StIdle;
        prio_rx_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Decode from the next state so the registered strobes line up with the access state.
  always_comb begin
    nic_en_d    = 1'b0;
    nic_wr_en_d = 1'b0;
    nic_addr_d  = 2'b00;
    nic_d_in_d  = '0;
    unique case (state_d)
      StTxStatRd: begin
        nic_en_d   = 1'b1;
        nic_addr_d = 2'b11;
      end
      StTxWr: begin
        nic_en_d    = 1'b1;
        nic_wr_en_d = 1'b1;
        nic_addr_d  = 2'b10;
        nic_d_in_d  = fifo_mem[rd_ptr_q];
      end
      StRxStatRd: begin
        nic_en_d   = 1'b1;
        nic_addr_d = 2'b01;
      end
      StRxDataRd: begin
        nic_en_d   = 1'b1;
        nic_addr_d = 2'b00;
      end
      default: ;
    endcase
  end

  assign nic_en    = nic_en_q;
  assign nic_wr_en = nic_wr_en_q;
  assign nic_addr  = nic_addr_q;
  assign nic_d_in  = nic_d_in_q;
  assign busy      = (state_q != StIdle);

  // ---------------------------------------------------------------------------------------
  // RX holding register and counters
  // ---------------------------------------------------------------------------------------
  logic [0:63]      rx_data_q;
  logic [CNT_W-1:0] tx_cnt_q, rx_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_cnt_q   <= '0;
    end else if (state_q == StRxCap) begin
      // A capture wins over a same-cycle drain.
      rx_data_q  <= nic_d_out;
      rx_valid_q <= 1'b1;
      rx_cnt_q   <= rx_cnt_q + CNT_W'(1);
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_cnt_q <= '0;
    end else if (pop) begin
      tx_cnt_q <= tx_cnt_q + CNT_W'(1);
    end
  end

  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign tx_sent_cnt = tx_cnt_q;
  assign rx_recv_cnt = rx_cnt_q;

endmodule

// File: tb/tb_nic_host_ctrl.sv
// Testbench for nic_host_ctrl: a behavioural NIC plus scoreboards for the TX and RX flit
// streams, random traffic, and directed reset/backpressure/arbitration scenarios.
module tb_nic_host_ctrl;

  localparam int unsigned Depth = 4;
  localparam int unsigned CntW  = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            tx_valid = 1'b0;
  logic            tx_ready;
  logic [0:63]     tx_data = '0;
  logic            rx_valid;
  logic            rx_ready = 1'b0;
  logic [0:63]     rx_data;
  logic [1:0]      nic_addr;
  logic [0:63]     nic_d_in;
  logic [0:63]     nic_d_out = '0;
  logic            nic_en;
  logic            nic_wr_en;
  logic [CntW-1:0] tx_sent_cnt;
  logic [CntW-1:0] rx_recv_cnt;
  logic            busy;

  always #5 clk = ~clk;

  nic_host_ctrl #(
    .TX_DEPTH (Depth),
    .CNT_W    (CntW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .nic_addr    (nic_addr),
    .nic_d_in    (nic_d_in),
    .nic_d_out   (nic_d_out),
    .nic_en      (nic_en),
    .nic_wr_en   (nic_wr_en),
    .tx_sent_cnt (tx_sent_cnt),
    .rx_recv_cnt (rx_recv_cnt),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: flit queues and occupancy, no knowledge of the sequencer internals.
  logic [63:0] exp_tx_q[$];
  logic [63:0] hold_q[$];
  logic [63:0] push_q[$];
  int          occ = 0;
  int          sent_m = 0;
  int          recv_m = 0;
  int          cap_timer = 0;
  logic [63:0] cap_flit = '0;

  // Behavioural NIC buffers.
  logic        out_full = 1'b0;
  logic        in_full = 1'b0;
  logic [63:0] in_buf = '0;
  logic        rd_pend = 1'b0;
  logic [63:0] rd_val = '0;

  // Knobs and observation flags.
  int          p_push = 0, p_ready = 0, p_drain = 0, p_fill = 0;
  bit          rst_req = 1'b1, arb_mode = 1'b0, last_valid = 1'b0, saw11 = 1'b0;
  logic [1:0]  last_poll = 2'b00;
  int          cyc = 0, last11_cyc = -100, last01_cyc = -100, n_wr = 0, n_rd00 = 0;
  logic [63:0] last_wr_data = '0;

  // NIC read data register.
  always @(posedge clk) begin
    if (rd_pend) nic_d_out <= rd_val;
  end

  task automatic poll_seen();
    if (arb_mode && last_valid) begin
      chk("arb_alternate", nic_addr, (last_poll == 2'b11) ? 2'b01 : 2'b11);
    end
    last_poll  = nic_addr;
    last_valid = 1'b1;
  endtask

  // One clock cycle: drive inputs for the coming edge, check visible state, advance model.
  task automatic step();
    logic exp_rdy;
    bit   wr_now, rd00_now;
    @(negedge clk);
    cyc++;
    saw11 = 1'b0;
    reset = rst_req;
    if (rst_req) begin
      tx_valid = 1'b0;
      rx_ready = 1'b0;
    end else begin
      if (push_q.size() > 0) begin
        tx_valid = 1'b1;
        tx_data  = push_q[0];
      end else begin
        tx_valid = (int'($urandom_range(99)) < p_push);
        tx_data  = {$urandom, $urandom};
      end
      rx_ready = (int'($urandom_range(99)) < p_ready);
    end

    // A flit read from in-buf lands in the holding register two cycles later.
    if (cap_timer > 0) begin
      cap_timer--;
      if (cap_timer == 0) begin
        chk("rx_no_overwrite", hold_q.size(), 0);
        hold_q.push_back(cap_flit);
        recv_m++;
      end
    end

    exp_rdy = (occ < int'(Depth));
    chk("tx_ready", tx_ready, exp_rdy);
    chk("rx_valid", rx_valid, hold_q.size() != 0);
    chk("tx_sent_cnt", tx_sent_cnt, sent_m % (1 << CntW));
    chk("rx_recv_cnt", rx_recv_cnt, recv_m % (1 << CntW));
    if (nic_en) chk("busy_on_access", busy, 1'b1);
    if (!busy) chk("idle_no_access", nic_en, 1'b0);

    if (rx_valid && rx_ready && hold_q.size() != 0) begin
      chk("rx_data", rx_data, hold_q[0]);
      void'(hold_q.pop_front());
    end

    rd_pend  = 1'b0;
    wr_now   = 1'b0;
    rd00_now = 1'b0;
    if (nic_en && nic_wr_en) begin
      wr_now = 1'b1;
      n_wr++;
      last_wr_data = nic_d_in;
      chk("wr_addr", nic_addr, 2'b10);
      chk("wr_buf_empty", out_full, 1'b0);
      chk("wr_latency", cyc - last11_cyc, 2);
      chk("wr_expected", exp_tx_q.size() != 0, 1'b1);
      if (exp_tx_q.size() != 0) begin
        chk("wr_data", nic_d_in, exp_tx_q[0]);
        void'(exp_tx_q.pop_front());
        occ--;
      end
      out_full = 1'b1;
      sent_m++;
    end else if (nic_en) begin
      rd_pend = 1'b1;
      case (nic_addr)
        2'b00: begin
          rd_val   = in_buf;
          rd00_now = 1'b1;
          n_rd00++;
          chk("rd_in_full", in_full, 1'b1);
          chk("rd_latency", cyc - last01_cyc, 2);
          cap_flit  = in_buf;
          cap_timer = 2;
          in_full   = 1'b0;
        end
        2'b01: begin
          rd_val     = {63'd0, in_full};
          last01_cyc = cyc;
          poll_seen();
        end
        2'b11: begin
          rd_val     = {63'd0, out_full};
          last11_cyc = cyc;
          saw11      = 1'b1;
          poll_seen();
        end
        default: rd_val = '0;
      endcase
    end

    if (tx_valid && exp_rdy) begin
      exp_tx_q.push_back(tx_data);
      occ++;
      if (push_q.size() > 0) void'(push_q.pop_front());
    end

    // Network side: drains the out-buffer and refills the in-buffer.
    if (out_full && !wr_now && int'($urandom_range(99)) < p_drain) out_full = 1'b0;
    if (!in_full && !rd00_now && int'($urandom_range(99)) < p_fill) begin
      in_full = 1'b1;
      in_buf  = {$urandom, $urandom};
    end

    if (rst_req) begin
      exp_tx_q.delete();
      hold_q.delete();
      occ        = 0;
      sent_m     = 0;
      recv_m     = 0;
      cap_timer  = 0;
      last_valid = 1'b0;
    end
  endtask

  initial begin
    bit found;

    // Reset values.
    rst_req = 1'b1;
    step();
    step();
    chk("rst_nic_en", nic_en, 1'b0);
    chk("rst_nic_wr_en", nic_wr_en, 1'b0);
    chk("rst_nic_addr", nic_addr, 2'b00);
    chk("rst_nic_d_in", nic_d_in, 64'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rx_data", rx_data, 64'd0);
    chk("rst_tx_ready", tx_ready, 1'b1);
    rst_req = 1'b0;

    // Single TX.
    p_ready = 100; p_fill = 0; p_drain = 100; p_push = 0;
    push_q.push_back(64'hA5A5_0000_0000_0001);
    n_wr = 0;
    for (int i = 0; i < 14; i++) step();
    chk("single_tx_writes", n_wr, 1);
    chk("single_tx_data", last_wr_data, 64'hA5A5_0000_0000_0001);
    chk("single_tx_cnt", tx_sent_cnt, 1);

    // RX path with the consumer stalled.
    p_ready = 0;
    in_buf  = 64'hDEAD_BEEF_0000_0007;
    in_full = 1'b1;
    n_rd00  = 0;
    for (int i = 0; i < 14; i++) step();
    chk("rx_dir_valid", rx_valid, 1'b1);
    chk("rx_dir_data", rx_data, 64'hDEAD_BEEF_0000_0007);
    chk("rx_dir_cnt", rx_recv_cnt, 1);
    p_fill = 100;
    for (int i = 0; i < 20; i++) step();
    chk("rx_stall_no_read", n_rd00, 1);

    // Reset while a TX sequence is in its status check.
    p_ready = 100; p_fill = 0; p_drain = 100;
    push_q.push_back({$urandom, $urandom});
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (saw11) found = 1'b1;
    end
    chk("rst_mid_tx_found", found, 1'b1);
    n_wr = 0;
    rst_req = 1'b1;
    step();
    step();
    rst_req = 1'b0;
    chk("rst_mid_nic_en", nic_en, 1'b0);
    chk("rst_mid_tx_ready", tx_ready, 1'b1);
    chk("rst_mid_rx_valid", rx_valid, 1'b0);
    chk("rst_mid_tx_cnt", tx_sent_cnt, 0);
    chk("rst_mid_rx_cnt", rx_recv_cnt, 0);
    for (int i = 0; i < 10; i++) step();
    chk("rst_mid_no_write", n_wr, 0);

    // TX backpressure: out-status stuck at 1, five pushes offered.
    p_drain = 0; out_full = 1'b1; p_fill = 0; p_ready = 100; p_push = 0;
    for (int i = 0; i < 5; i++) push_q.push_back({$urandom, $urandom});
    n_wr = 0;
    for (int i = 0; i < 10; i++) step();
    arb_mode = 1'b1; last_valid = 1'b0;
    for (int i = 0; i < 40; i++) step();
    arb_mode = 1'b0;
    chk("bp_full", tx_ready, 1'b0);
    chk("bp_no_write", n_wr, 0);
    chk("bp_fifth_refused", push_q.size(), 1);
    push_q.delete();
    p_drain = 100;
    for (int i = 0; i < 45; i++) step();
    chk("bp_release_writes", n_wr, 4);
    chk("bp_fifo_empty", exp_tx_q.size(), 0);

    // Arbitration under continuous demand on both sides.
    p_push = 100; p_fill = 100; p_ready = 100; p_drain = 100;
    for (int i = 0; i < 10; i++) step();
    arb_mode = 1'b1; last_valid = 1'b0; n_wr = 0; n_rd00 = 0;
    for (int i = 0; i < 90; i++) step();
    arb_mode = 1'b0;
    chk("arb_tx_progress", n_wr > 5, 1'b1);
    chk("arb_rx_progress", n_rd00 > 5, 1'b1);

    // Random traffic with occasional resets; counters wrap at 2^CntW.
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) begin
        p_push  = int'($urandom_range(100));
        p_ready = int'($urandom_range(100));
        p_drain = int'($urandom_range(100));
        p_fill  = int'($urandom_range(100));
      end
      rst_req = ($urandom_range(699) == 0);
      step();
    end
    rst_req = 1'b0;

    // Drain everything outstanding.
    p_push = 0; p_fill = 0; p_drain = 100; p_ready = 100;
    for (int i = 0; i < 120; i++) step();
    chk("final_tx_drained", exp_tx_q.size(), 0);
    chk("final_rx_drained", hold_q.size(), 0);
    chk("final_in_consumed", in_full, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
